// File: rtl/bnn_vad_pkg.sv
// Shared definitions for the VAD binarised feature path.
//   FEAT_W, WIN_W, WIN_STEP : default feature word / window / step sizes
//   window_count()          : number of windows a word yields
//   wf_state_t              : window fetcher state encoding
package bnn_vad_pkg;

    localparam int FEAT_W   = 20;
    localparam int WIN_W    = 5;
    localparam int WIN_STEP = 3;

    function automatic int window_count(input int in_w, input int win_w, input int step);
        return (in_w - win_w) / step + 1;
    endfunction

    typedef enum logic {
        WF_IDLE  = 1'b0,
        WF_SHIFT = 1'b1
    } wf_state_t;

endpackage

// File: rtl/bnn_window_fetch.sv
// Sliding-window serializer: takes one IN_W-bit feature word over valid/ready
// and emits N overlapping WIN_W-bit windows, MSB-first, STEP bits apart.
// Optional one-entry prefetch register under WINFETCH_PREFETCH_EN gives
// back-to-back throughput of N cycles per word.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               sync clear of held and prefetched words
//   in_valid/in_ready   input word handshake, in_data = word
//   out_valid/out_ready window handshake
//   out_data            current window, out_idx its index, out_last on idx N-1
//   empty               no word held and nothing prefetched
module bnn_window_fetch
    import bnn_vad_pkg::*;
#(
    parameter int IN_W  = bnn_vad_pkg::FEAT_W,
    parameter int WIN_W = bnn_vad_pkg::WIN_W,
    parameter int STEP  = bnn_vad_pkg::WIN_STEP,
    localparam int N     = bnn_vad_pkg::window_count(IN_W, WIN_W, STEP),
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             empty
);

    if (WIN_W < 1 || WIN_W > IN_W || STEP < 1 || ((IN_W - WIN_W) % STEP) != 0) begin : g_bad_cfg
        $error("bnn_window_fetch: illegal IN_W/WIN_W/STEP combination");
    end

    wf_state_t        state, state_n;
    logic [IN_W-1:0]  sr, sr_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             in_hs, out_hs, is_last;

`ifdef WINFETCH_PREFETCH_EN
    logic            pf_valid, pf_valid_n;
    logic [IN_W-1:0] pf_data, pf_data_n;

    // Only the prefetch slot gates input, so a word can land while windows drain.
    assign in_ready = !pf_valid;
    assign empty    = (state == WF_IDLE) && !pf_valid;
`else
    assign in_ready = (state == WF_IDLE);
    assign empty    = (state == WF_IDLE);
`endif

    assign in_hs     = in_valid && in_ready;
    assign out_valid = (state == WF_SHIFT);
    assign out_hs    = out_valid && out_ready;
    assign is_last   = (idx == IDX_W'(N - 1));
    assign out_last  = out_valid && is_last;
    assign out_data  = sr[IN_W-1 -: WIN_W];
    assign out_idx   = idx;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        idx_n   = idx;
`ifdef WINFETCH_PREFETCH_EN
        pf_valid_n = pf_valid;
        pf_data_n  = pf_data;
`endif
        if (flush) begin
            // Flush wins over any handshake this cycle; an input word is dropped.
            state_n = WF_IDLE;
            sr_n    = '0;
            idx_n   = '0;
`ifdef WINFETCH_PREFETCH_EN
            pf_valid_n = 1'b0;
`endif
        end else begin
            unique case (state)
                WF_IDLE: begin
`ifdef WINFETCH_PREFETCH_EN
                    // A word captured on the final handshake waits one cycle here.
                    if (pf_valid) begin
                        sr_n       = pf_data;
                        idx_n      = '0;
                        state_n    = WF_SHIFT;
                        pf_valid_n = 1'b0;
                    end else
`endif
                    if (in_hs) begin
                        sr_n    = in_data;
                        idx_n   = '0;
                        state_n = WF_SHIFT;
                    end
                end
                WF_SHIFT: begin
                    if (out_hs) begin
                        if (!is_last) begin
                            sr_n  = sr << STEP;
                            idx_n = idx + IDX_W'(1);
                        end else begin
`ifdef WINFETCH_PREFETCH_EN
                            if (pf_valid) begin
                                sr_n       = pf_data;
                                idx_n      = '0;
                                pf_valid_n = 1'b0;
                            end else
`endif
                            begin
                                state_n = WF_IDLE;
                                idx_n   = '0;
                            end
                        end
                    end
`ifdef WINFETCH_PREFETCH_EN
                    // in_ready implies the slot is free, so this never collides
                    // with the slot being drained above.
                    if (in_hs) begin
                        pf_data_n  = in_data;
                        pf_valid_n = 1'b1;
                    end
`endif
                end
                default: state_n = WF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WF_IDLE;
            sr    <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            idx   <= idx_n;
        end
    end

`ifdef WINFETCH_PREFETCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
            pf_data  <= '0;
        end else begin
            pf_valid <= pf_valid_n;
            pf_data  <= pf_data_n;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_window_fetch.sv
module tb_bnn_window_fetch;

    localparam int IN_W  = 20;
    localparam int WIN_W = 5;
    localparam int STEP  = 3;
    localparam int N     = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        empty;

    // second instance: IN_W=16, WIN_W=4, STEP=4
    logic        flush2 = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [15:0] in_data2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [3:0]  out_data2;
    logic [1:0]  out_idx2;
    logic        out_last2;
    logic        empty2;

    bnn_window_fetch #(.IN_W(IN_W), .WIN_W(WIN_W), .STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .empty(empty)
    );

    bnn_window_fetch #(.IN_W(16), .WIN_W(4), .STEP(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_idx(out_idx2), .out_last(out_last2), .empty(empty2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // reference model: window k is the WIN_W bits starting k*STEP below the MSB
    typedef struct {
        logic [4:0] d;
        int         idx;
        logic       last;
    } exp_t;

    exp_t sbq[$];
    int   hs_cyc[$];

    function automatic void push_word(input logic [19:0] w);
        exp_t e;
        logic [31:0] wl;
        wl = 32'(w);
        for (int k = 0; k < N; k++) begin
            e.d    = 5'((wl >> (IN_W - WIN_W - k * STEP)) & 32'h1F);
            e.idx  = k;
            e.last = (k == N - 1);
            sbq.push_back(e);
        end
    endfunction

    // ready driver: random or fixed, updated shortly after each rising edge
    logic rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end

    // monitor / scoreboard
    logic       held_valid = 1'b0;
    logic [4:0] held_d;
    logic [2:0] held_i;
    exp_t       me;

    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (out_valid) begin
                if (held_valid) begin
                    check("hold_data", 32'(out_data), 32'(held_d));
                    check("hold_idx", 32'(out_idx), 32'(held_i));
                end
                if (out_ready) begin
                    hs_cyc.push_back(cyc);
                    if (sbq.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_window: got data %0h idx %0d, none expected", out_data, out_idx);
                    end else begin
                        me = sbq.pop_front();
                        check("win_data", 32'(out_data), 32'(me.d));
                        check("win_idx", 32'(out_idx), 32'(me.idx));
                        check("win_last", 32'(out_last), 32'(me.last));
                    end
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held_d     = out_data;
                    held_i     = out_idx;
                end
            end else begin
                if (held_valid) check("valid_held", 32'(out_valid), 32'd1);
                held_valid = 1'b0;
            end
        end
    end

    // call at posedge+#1; returns at posedge+#1 after the accepting edge
    task automatic send(input logic [19:0] w, output int acc);
        int t;
        t = 0;
        acc = -1;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
        end else begin
            acc = cyc;
            push_word(w);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_done", 32'(sbq.size()), 32'd0);
        check("empty_after", 32'(empty), 32'd1);
        check("valid_after", 32'(out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int acc1, acc2, t;
        logic [31:0] wl2;

        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed word, ready held high
        rdy_fixed = 1'b1;
        send(20'hABCDE, acc1);
        drain();

        // backpressure: same word plus random words, random ready
        rdy_rand = 1'b1;
        send(20'hABCDE, acc1);
        for (int i = 0; i < 8; i++) send(20'($urandom), acc1);
        drain();
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // back-to-back timing
        hs_cyc.delete();
        send(20'h12345, acc1);
        send(20'hFEDCB, acc2);
        drain();
        if (hs_cyc.size() >= 12) begin
            check("b2b_first_win", 32'(hs_cyc[0] - acc1), 32'd1);
`ifdef WINFETCH_PREFETCH_EN
            check("b2b_word2_start", 32'(hs_cyc[6] - acc1), 32'd7);
            check("b2b_span", 32'(hs_cyc[11] - hs_cyc[0]), 32'd11);
`else
            check("b2b_word2_start", 32'(hs_cyc[6] - acc1), 32'd8);
            check("b2b_span", 32'(hs_cyc[11] - hs_cyc[0]), 32'd12);
`endif
        end else begin
            check("b2b_count", 32'(hs_cyc.size()), 32'd12);
        end

        // flush at idx 3 with a word pending at the input
        send(20'h5A5A5, acc1);
        t = 0;
        while (out_idx != 3'd3 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("flush_reach_idx3", 32'(out_idx), 32'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 20'h0F0F0;
        sbq.delete();
        held_valid = 1'b0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("flush_no_accept", 32'(out_valid), 32'd0);

        // async reset mid-word
        send(20'h3C3C3, acc1);
        t = 0;
        while (out_idx != 3'd2 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sbq.delete();
        held_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(20'hC0FFE, acc1);
        drain();

        // parameter sweep instance: windows are the nibbles MSB-first
        for (int w = 0; w < 4; w++) begin
            in_data2  = (w == 0) ? 16'h1234 : 16'($urandom);
            wl2       = 32'(in_data2);
            in_valid2 = 1'b1;
            t = 0;
            @(negedge clk);
            while (!in_ready2 && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                t = 0;
                @(negedge clk);
                while (!out_valid2 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check("sweep_data", 32'(out_data2), (wl2 >> (12 - 4 * k)) & 32'hF);
                check("sweep_idx", 32'(out_idx2), 32'(k));
                check("sweep_last", 32'(out_last2), 32'(k == 3));
                @(posedge clk);
                #1;
            end
            check("sweep_empty", 32'(empty2), 32'd1);
        end

        check("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/bnn_window_fetch.md
# bnn_window_fetch

- Parametrised sliding-window serializer for the VAD feature path.
- Accepts one packed feature word over a valid/ready handshake and emits overlapping WIN_W-bit windows, stepping STEP bits MSB-first, one window per output handshake. It flags the last window of each word.
- Sits between the feature buffer and the binarised convolution front end. It replaces the fixed 20-bit/5-bit/step-3 fetcher with full flow control.

## Interface
- IN_W, default 20: input word width.
- WIN_W, default 5: window width; 1 ≤ WIN_W ≤ IN_W.
- STEP, default 3: shift between consecutive windows; 1 ≤ STEP; (IN_W−WIN_W) % STEP == 0, enforced by elaboration-time check.
- Derived constant N = (IN_W−WIN_W)/STEP + 1 (6 with defaults); IDX_W = max(1, clog2(N)).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear: drops current and prefetched words.
- in_valid  in  1  input word available.
- in_ready  out  1  block can accept a word.
- in_data  in  IN_W  packed feature word.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts window.
- out_data  out  WIN_W  current window.
- out_idx  out  IDX_W  window index 0..N−1 within word.
- out_last  out  1  high with out_valid when out_idx == N−1.
- empty  out  1  high when no word held (IDLE and no prefetch).

## Operation
- Two states:
  - IDLE: no word.
  - SHIFT: word held in shift register `sr`, window counter `idx`.
- IDLE → SHIFT on input handshake (in_valid && in_ready): sr ← in_data, idx ← 0.
- out_data = sr[IN_W−1 -: WIN_W], i.e. window k = in_data[IN_W−1−k·STEP -: WIN_W].
- Output handshake with idx < N−1: sr ← sr << STEP (zero fill), idx ← idx+1.
- Output handshake with idx == N−1 (last):
  - Next word available (prefetch, see Configuration): load it, stay in SHIFT.
  - Otherwise: go to IDLE.
- out_valid = (state == SHIFT); out_last = out_valid && idx == N−1.
- No handshake: all state holds. out_data and out_idx are stable while out_valid && !out_ready.
- flush has priority over every handshake in the same cycle: state ← IDLE, idx ← 0, prefetch cleared; the input handshake in that cycle is discarded.
- Reset mid-word: asynchronous, and the word is lost.
- Reset values: state IDLE, sr 0, idx 0, out_valid 0, out_last 0, out_data 0, out_idx 0, empty 1, in_ready 1.

## Timing
- Latency: accepted word → first window out_valid: 1 cycle (registered).
- With the macro undefined:
  - in_ready = (state == IDLE).
  - A word occupies N+1 cycles with out_ready held high.
- in_ready must not depend combinationally on out_ready. out_valid must not depend combinationally on in_valid.
- Once asserted, out_valid stays high until its handshake. Only flush or reset may drop it.

## Configuration
- WINFETCH_PREFETCH_EN defined:
  - Adds a one-entry prefetch register, and in_ready = !pf_valid.
  - A word accepted while in SHIFT goes to the prefetch register.
  - On the last-window handshake with pf_valid, the prefetched word loads into sr, pf_valid clears, and out_valid stays high.
  - Back-to-back throughput: exactly N cycles per word.
  - A simultaneous last handshake and input handshake with pf_valid = 0 and state SHIFT also loads in_data into the prefetch register.
- WINFETCH_PREFETCH_EN undefined: no prefetch register; behaviour as in Timing.

## Structure
- Shared package bnn_vad_pkg holds:
  - window_count function (computes N);
  - default constants FEAT_W=20, WIN_W=5, WIN_STEP=3.
- Single module, no sub-modules. The optional prefetch register is inline, under the macro.

## Test plan
- Reset, then in_data=20'hABCDE with out_ready=1 → out_data 0x15, 0x0B, 0x1E, 0x13, 0x1B, 0x1E on out_idx 0..5; out_last only on idx 5; empty=1 after.
- Backpressure: out_ready toggled randomly on same word → identical window sequence, with out_data held while stalled.
- Two words back-to-back, out_ready=1:
  - Without macro: windows of word 2 start at cycle 8 after first acceptance (N+1 = 7 cycles per word).
  - With macro: windows contiguous, 12 windows in 12 cycles.
- flush asserted at idx 3 with a word pending at input → out_valid 0 next cycle; the pending word is not accepted that cycle; in_ready 1 after.
- rst_n pulsed low mid-word (async, between edges) → outputs at reset values immediately; next word restarts at idx 0.
- Parameter sweep IN_W=16, WIN_W=4, STEP=4 → N=4, windows equal the nibbles MSB-first (16'h1234 → 1,2,3,4).
